pulse_train_gen: RTL and testbench

Generates a programmable train of rectangular pulses on a single output, for downstream rising-edge counters and trigger inputs on the head-worn unit. On an accepted start it emits exactly num_pulses pulses. Each pulse is high for high_cycles and separated by low_cycles. It reports progress, completion and abort status to the control logic.

---
 rtl/pulse_train_pkg.sv | 20 ++
 rtl/pulse_train_gen_phase_timer.sv | 36 +++
 rtl/pulse_train_gen.sv | 163 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types, default widths and the phase-duration helper for the pulse train generator.
package pulse_train_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned TIME_W_DEF = 16;
  // Widest duration field the load helper can accept.
  localparam int unsigned DUR_MAX_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Timer load value for a phase of d cycles; a zero duration behaves like one cycle.
  function automatic logic [DUR_MAX_W-1:0] dur_load(input logic [DUR_MAX_W-1:0] d);
    return (d == '0) ? '0 : (d - DUR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Down-counter timing one HIGH or LOW phase; reloads itself with load_val when it expires.
module phase_timer #(
  parameter int unsigned TIME_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic              expire
);

  logic [TIME_W-1:0] count_d;
  logic [TIME_W-1:0] count_q;

  // Next count: forced load, automatic reload at zero (next phase entry), else count down.
  always_comb begin
    count_d = count_q;
    if (load || (count_q == '0)) begin
      count_d = load_val;
    end else begin
      count_d = count_q - TIME_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0) && !load;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: N pulses of H high cycles separated by L low cycles.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_pulses,
  input  logic [TIME_W-1:0] high_cycles,
  input  logic [TIME_W-1:0] low_cycles,
  output logic              s_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  pulses_sent
);

  state_e            state_d, state_q;
  logic              s_out_d, s_out_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              aborted_d, aborted_q;
  logic [CNT_W-1:0]  pulses_sent_d, pulses_sent_q;
  logic [CNT_W-1:0]  num_d, num_q;
  logic [TIME_W-1:0] high_d, high_q;
  logic [TIME_W-1:0] low_d, low_q;

  logic              accept_c;
  logic              timer_load_c;
  logic [TIME_W-1:0] timer_load_val_c;
  logic              timer_expire;

  assign accept_c = start && !abort;

  // Timer is held loaded while idle; in a phase it preloads the length of the phase that follows.
  always_comb begin
    timer_load_c     = (state_q == IDLE);
    timer_load_val_c = TIME_W'(dur_load(DUR_MAX_W'(high_cycles)));
    case (state_q)
      HIGH:    timer_load_val_c = TIME_W'(dur_load(DUR_MAX_W'(low_q)));
      LOW:     timer_load_val_c = TIME_W'(dur_load(DUR_MAX_W'(high_q)));
      default: timer_load_val_c = TIME_W'(dur_load(DUR_MAX_W'(high_cycles)));
    endcase
  end

  phase_timer #(
    .TIME_W(TIME_W)
  ) u_phase_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load_c),
    .load_val (timer_load_val_c),
    .expire   (timer_expire)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    s_out_d       = s_out_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    aborted_d     = aborted_q;
    pulses_sent_d = pulses_sent_q;
    num_d         = num_q;
    high_d        = high_q;
    low_d         = low_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          num_d         = num_pulses;
          high_d        = high_cycles;
          low_d         = low_cycles;
          aborted_d     = 1'b0;
          pulses_sent_d = '0;
          if (num_pulses == '0) begin
            done_d = 1'b1;
          end else begin
            state_d       = HIGH;
            s_out_d       = 1'b1;
            busy_d        = 1'b1;
            pulses_sent_d = CNT_W'(1);
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_d   = IDLE;
          s_out_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (timer_expire) begin
          s_out_d = 1'b0;
          if (pulses_sent_q == num_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
          end
        end
      end

      LOW: begin
        if (abort) begin
          state_d   = IDLE;
          s_out_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (timer_expire) begin
          state_d       = HIGH;
          s_out_d       = 1'b1;
          pulses_sent_d = pulses_sent_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        s_out_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, output and latched-configuration registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      s_out_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      pulses_sent_q <= '0;
      num_q         <= '0;
      high_q        <= '0;
      low_q         <= '0;
    end else begin
      state_q       <= state_d;
      s_out_q       <= s_out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      pulses_sent_q <= pulses_sent_d;
      num_q         <= num_d;
      high_q        <= high_d;
      low_q         <= low_d;
    end
  end

  assign s_out       = s_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign pulses_sent = pulses_sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: each accepted train pushes its expected outcome,
// a monitor accumulates the observed waveform and checks it on every done strobe.
module tb_pulse_train_gen;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TIME_W = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_pulses;
  logic [TIME_W-1:0] high_cycles;
  logic [TIME_W-1:0] low_cycles;
  logic              s_out;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [CNT_W-1:0]  pulses_sent;

  typedef struct {
    int acc;    // cycle in which start was accepted
    int lat;    // cycles from accept to done
    int ab;     // expected aborted flag
    int ps;     // expected pulses_sent at done
    int edges;  // rising edges on s_out
    int hi;     // cycles with s_out high
    int bz;     // cycles with busy high
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  pulse_train_gen #(
    .CNT_W  (CNT_W),
    .TIME_W (TIME_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .abort       (abort),
    .num_pulses  (num_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .s_out       (s_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .pulses_sent (pulses_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: pulse i starts at offset 1+i*P; the train ends after N*H+(N-1)*L
  // busy cycles or at the abort cycle, whichever comes first.
  function automatic exp_t model(int n, int h, int l, int k_abort);
    exp_t e;
    int he, le, p, tot, kend, ph;
    he   = (h == 0) ? 1 : h;
    le   = (l == 0) ? 1 : l;
    p    = he + le;
    tot  = (n == 0) ? 0 : n * he + (n - 1) * le;
    kend = (k_abort > 0 && k_abort <= tot) ? k_abort : tot;
    e.ab    = (k_abort > 0 && k_abort <= tot) ? 1 : 0;
    e.edges = 0;
    e.hi    = 0;
    for (int c = 1; c <= kend; c++) begin
      ph = (c - 1) % p;
      if (ph == 0) e.edges++;
      if (ph < he) e.hi++;
    end
    e.ps  = e.edges;
    e.bz  = kend;
    e.lat = kend + 1;
    e.acc = 0;
    return e;
  endfunction

  function automatic int busy_total(int n, int h, int l);
    int he, le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    return (n == 0) ? 0 : n * he + (n - 1) * le;
  endfunction

  // Monitor: accumulate waveform statistics, compare against the scoreboard on done.
  initial begin : monitor
    int   edges, hi, bz;
    logic prev;
    exp_t e;
    edges = 0; hi = 0; bz = 0; prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        edges = 0; hi = 0; bz = 0; prev = 1'b0;
      end else begin
        if (s_out && !prev) edges++;
        if (s_out) hi++;
        if (busy) bz++;
        prev = s_out;
        if (done) begin
          chk("done_expected", (sb.size() > 0) ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_latency", cyc - e.acc, e.lat);
            chk("aborted", int'(aborted), e.ab);
            chk("pulses_sent", int'(pulses_sent), e.ps);
            chk("rising_edges", edges, e.edges);
            chk("high_cycles_seen", hi, e.hi);
            chk("busy_cycles_seen", bz, e.bz);
            chk("busy_at_done", int'(busy), 0);
            chk("s_out_at_done", int'(s_out), 0);
          end
          edges = 0; hi = 0; bz = 0;
        end
      end
    end
  end

  task automatic rand_cfg();
    num_pulses  = CNT_W'($urandom_range(0, 15));
    high_cycles = TIME_W'($urandom_range(0, 9));
    low_cycles  = TIME_W'($urandom_range(0, 9));
  endtask

  // Issue one train starting at the current negedge; returns at the negedge of the done cycle.
  task automatic run_train(int n, int h, int l, int k_abort, bit junk);
    exp_t e;
    start       = 1'b1;
    abort       = 1'b0;
    num_pulses  = CNT_W'(n);
    high_cycles = TIME_W'(h);
    low_cycles  = TIME_W'(l);
    e     = model(n, h, l, k_abort);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    rand_cfg();
    while (cyc < e.acc + e.lat) begin
      abort = (k_abort > 0 && cyc == e.acc + k_abort) ? 1'b1 : 1'b0;
      if (junk && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        rand_cfg();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Idle gap; sometimes start and abort together, which must not be accepted.
  task automatic idle_gap(int g);
    for (int i = 0; i < g; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1;
        abort = 1'b1;
        rand_cfg();
      end else begin
        start = 1'b0;
        abort = $urandom_range(0, 1) == 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n, h, l, k, tot;
    resetn      = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    num_pulses  = '0;
    high_cycles = '0;
    low_cycles  = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_out", int'(s_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_pulses_sent", int'(pulses_sent), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed trains.
    run_train(3, 2, 3, 0, 1'b0);
    idle_gap(2);
    run_train(0, 5, 5, 0, 1'b0);
    idle_gap(1);
    run_train(2, 0, 0, 0, 1'b0);
    idle_gap(1);
    run_train(5, 4, 4, 7, 1'b0);
    idle_gap(1);
    run_train(5, 4, 4, 9, 1'b0);
    idle_gap(1);
    run_train(2, 3, 2, 3, 1'b0);   // abort coincides with phase expiry
    idle_gap(1);
    run_train(1, 2, 0, 2, 1'b0);   // abort on the final cycle of the last pulse
    idle_gap(1);
    run_train(2, 1, 1, 0, 1'b1);   // start re-pulsed mid-train
    run_train(1, 1, 1, 0, 1'b0);   // accepted in the done cycle of the previous train
    run_train(15, 1, 0, 0, 1'b0);  // maximum pulse count
    idle_gap(2);

    // Asynchronous reset in the middle of a HIGH phase.
    start       = 1'b1;
    num_pulses  = CNT_W'(3);
    high_cycles = TIME_W'(4);
    low_cycles  = TIME_W'(2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_s_out", int'(s_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_pulses_sent", int'(pulses_sent), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_train(2, 2, 1, 0, 1'b0);

    // Randomized trains.
    for (int t = 0; t < 60; t++) begin
      n   = $urandom_range(0, 6);
      h   = $urandom_range(0, 4);
      l   = $urandom_range(0, 4);
      tot = busy_total(n, h, l);
      k   = (tot > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, tot) : 0;
      run_train(n, h, l, k, 1'b1);
      idle_gap($urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
